maxpool_window_buffer: RTL

MAXPOOL_WINDOW_BUFFER -- requirements
Module: maxpool_window_buffer

---
 rtl/maxpool_window_buffer_if.sv | 31 +++
 rtl/maxpool_window_buffer.sv | 104 ++++++++++
 2 files changed

// File: rtl/maxpool_window_buffer_if.sv
// Stream bundle for the max-pool window buffer: pixel input channel and KxK window output channel.
// Handshake: a beat transfers on the rising edge where valid && ready; valid never waits on ready.
interface maxpool_window_buffer_if #(
    parameter int WIDTH = 16,
    parameter int K     = 2
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH*K*K-1:0]   out_window_flat;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_window_flat
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_window_flat
    );
endinterface

// File: rtl/maxpool_window_buffer.sv
// Raster-order pixel stream to stride-K, non-overlapping KxK windows for a max-pool stage.
// Optional macro MAXPOOL_WINDOW_LAST_EN adds out_last, flagging the final window of each frame.
module maxpool_window_buffer #(
    parameter int K     = 2,
    parameter int WIDTH = 16,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    maxpool_window_buffer_if.slave  bus
`ifdef MAXPOOL_WINDOW_LAST_EN
    ,
    output logic                    out_last
`endif
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int KW = $clog2(K);

    localparam logic [CW-1:0] MAX_COL = CW'(IMG_W - 1);
    localparam logic [RW-1:0] MAX_ROW = RW'(IMG_H - 1);
    localparam logic [KW-1:0] K_TOP   = KW'(K - 1);

    logic [CW-1:0]          col;
    logic [RW-1:0]          row;
    logic [KW-1:0]          kc;
    logic [KW-1:0]          kr;
    logic [WIDTH-1:0]       line_mem [K][IMG_W];
    logic                   xfer;
    logic                   win_done;
    logic [CW-1:0]          col_base;
    logic [WIDTH*K*K-1:0]   win_next;

    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign xfer         = bus.in_valid && bus.in_ready;
    // Trailing columns/rows restart kc/kr at 0 and hold fewer than K pixels, so they never reach K_TOP.
    assign win_done     = xfer && (kr == K_TOP) && (kc == K_TOP);
    assign col_base     = col - CW'(K - 1);

`ifdef MAXPOOL_WINDOW_LAST_EN
    localparam logic [CW-1:0] LAST_COL = CW'((IMG_W / K) * K - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'((IMG_H / K) * K - 1);
    logic win_last;
    assign win_last = (row == LAST_ROW) && (col == LAST_COL);
`endif

    // Slot r of line_mem holds window row r; the completing pixel bypasses storage.
    for (genvar gr = 0; gr < K; gr++) begin : g_row
        for (genvar gc = 0; gc < K; gc++) begin : g_col
            if (gr == K - 1 && gc == K - 1) begin : g_new
                assign win_next[WIDTH*(gr*K+gc) +: WIDTH] = bus.in_data;
            end else begin : g_mem
                assign win_next[WIDTH*(gr*K+gc) +: WIDTH] = line_mem[gr][col_base + CW'(gc)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (xfer) begin
            line_mem[kr][col] <= bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col                 <= '0;
            row                 <= '0;
            kc                  <= '0;
            kr                  <= '0;
            bus.out_valid       <= 1'b0;
            bus.out_window_flat <= '0;
`ifdef MAXPOOL_WINDOW_LAST_EN
            out_last            <= 1'b0;
`endif
        end else begin
            if (xfer) begin
                if (col == MAX_COL) begin
                    col <= '0;
                    kc  <= '0;
                    if (row == MAX_ROW) begin
                        row <= '0;
                        kr  <= '0;
                    end else begin
                        row <= row + RW'(1);
                        kr  <= (kr == K_TOP) ? '0 : kr + KW'(1);
                    end
                end else begin
                    col <= col + CW'(1);
                    kc  <= (kc == K_TOP) ? '0 : kc + KW'(1);
                end
            end
            if (win_done) begin
                bus.out_valid       <= 1'b1;
                bus.out_window_flat <= win_next;
`ifdef MAXPOOL_WINDOW_LAST_EN
                out_last            <= win_last;
`endif
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule
